ps2_keyboard_ctrl: RTL
======================

// Module: ps2_keyboard_ctrl
// PURPOSE
//  System-clock controller sequencing the PS/2 keyboard receive path: syncs PS/2 clk/data,
//  frames 11-bit packets, checks parity/stop, enforces inter-edge timeout, folds E0/F0
//  prefixes into key events. Sits between PS/2 pins and game input logic; valid/ready out.
// PARAMETERS
//  TIMEOUT_CYCLES  5000  CLK cycles allowed between PS/2 falling edges inside a frame
//  FIFO_DEPTH      4     event FIFO entries (power of 2, >=2); used only with PS2_EVENT_FIFO_EN
// PORTS
//  CLK          in   1  system clock, all logic on posedge
//  Resetn       in   1  reset, asynchronous, active-low
//  ps2_clk      in   1  raw PS/2 clock pin (async)
//  ps2_data     in   1  raw PS/2 data pin (async)
//  ev_valid     out  1  key event available
//  ev_ready     in   1  consumer accepts event when ev_valid&&ev_ready at posedge CLK
//  ev_code      out  8  scan code (prefixes removed)
//  ev_release   out  1  1 = key released (F0 seen before code)
//  ev_extended  out  1  1 = E0 seen before code
//  frame_err    out  1  1-cycle pulse: parity, stop or timeout error
//  overflow     out  1  1-cycle pulse: decoded event dropped, no space
//  busy         out  1  frame FSM not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, bit count 0, prefix flags 0, storage empty; sync FFs to 1.
//  - ps2_clk/ps2_data each via 2-FF synchronizer; fall = clk_sync_q & ~clk_sync; data sampled
//    on the same cycle as fall.
//  - FSM (acts only on fall except timeout): IDLE: data=0 -> DATA, cnt=0; data=1 -> stay (glitch).
//    DATA: shift in LSB first, after 8th bit -> PARITY. PARITY: store bit -> STOP.
//    STOP: ok if data=1 and ^{byte,parity}=1 (odd); else frame_err; always -> IDLE.
//  - Timeout: counter cleared on every fall and in IDLE; reaching TIMEOUT_CYCLES outside IDLE
//    -> IDLE, frame_err pulse, prefix flags cleared. Partial byte discarded.
//  - Decoder on good byte: 8'hE0 -> ext=1; 8'hF0 -> rel=1; else push {code,rel,ext}, clear both.
//    Error frame clears ext/rel. Repeated prefixes (E0 E0) just keep flag set.
//  - Event visible on ev_* exactly 1 CLK after the STOP-edge cycle (when storage was empty).
//  - ev_code/ev_release/ev_extended stable while ev_valid && !ev_ready.
//  - Push when full: event dropped, overflow pulse, stored contents untouched.
//  - Reset mid-frame: immediate abort, no event, no error pulse.
// CONFIGURATION
//  PS2_EVENT_FIFO_EN defined: events buffered in FIFO_DEPTH-entry FIFO; full = FIFO_DEPTH
//    entries; simultaneous push+pop when full is accepted (pop frees slot, no overflow);
//    pointers wrap modulo FIFO_DEPTH.
//  Undefined: single holding register; push while ev_valid && !ev_ready -> overflow;
//    push in same cycle as accepted pop -> new event loaded, no overflow.
// STRUCTURE
//  ps2_pkg: frame state enum (IDLE,DATA,PARITY,STOP), PS2_EXT_CODE=8'hE0,
//    PS2_BREAK_CODE=8'hF0, packed key-event struct {code[7:0],release,extended}.
//  Sub-module ps2_event_fifo (width = event struct, depth param, valid/ready pop, push/full);
//    instantiated only under PS2_EVENT_FIFO_EN.
// TESTING (PS/2 bit period 40 CLK unless stated)
//  1 Frame 0x1C, parity 0, stop 1 -> one event code=1C rel=0 ext=0; no frame_err.
//  2 Sequence E0,F0,75 -> single event code=75 rel=1 ext=1; prefixes emit nothing.
//  3 Frame 0x1C with parity 1 -> frame_err pulse, no event; next good 0x29 decodes normally.
//  4 Stop after 4 data bits (no edges > TIMEOUT_CYCLES) -> frame_err, busy=0; next frame ok.
//  5 ev_ready=0, send 5 codes -> FIFO: 4 held in order, 5th overflow; no FIFO: 1st held, 4 overflows.
//  6 Resetn low mid-DATA -> busy=0, ev_valid=0 asynchronously; after release next frame ok.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 keyboard receive path: frame states, prefix codes, key event.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       is_release;
    logic       is_extended;
  } key_event_t;

  // PS/2 uses odd parity over the data byte plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic parity_bit);
    return ^{data_byte, parity_bit};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Power-of-two event FIFO: push/full on the write side, valid/ready on the read side.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       Resetn,
  input  logic       push_i,
  input  key_event_t push_data_i,
  output logic       full_o,
  output logic       pop_valid_o,
  input  logic       pop_ready_i,
  output key_event_t pop_data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  key_event_t    mem_q [DEPTH];
  key_event_t    mem_d [DEPTH];
  logic          pop, wr;

  assign full_o      = (count_q == (AW+1)'(DEPTH));
  assign pop_valid_o = (count_q != '0);
  assign pop_data_o  = mem_q[rptr_q];

  // A pop in the same cycle frees a slot, so a push against a full FIFO still lands.
  assign pop = pop_valid_o & pop_ready_i;
  assign wr  = push_i & (~full_o | pop);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr) begin
      mem_d[wptr_q] = push_data_i;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) rptr_d = rptr_q + AW'(1);
    if (wr && !pop) count_d = count_q + (AW+1)'(1);
    else if (pop && !wr) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 keyboard receiver: sync, 11-bit framing, parity/stop/timeout checks, E0/F0 folding.
// Define PS2_EVENT_FIFO_EN to buffer events in a FIFO; otherwise a single holding register.
module ps2_keyboard_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       CLK,
  input  logic       Resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_release,
  output logic       ev_extended,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic clk_meta_q, clk_sync_q, clk_prev_q, data_meta_q, data_sync_q;
  logic fall;

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  frame_state_e    state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            ext_q, ext_d, rel_q, rel_d;
  logic            frame_err_q, overflow_q;
  logic            byte_done, frame_bad, timeout, err_now;
  logic            push, pop, drop;
  key_event_t      push_ev, out_ev;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    timeout   = 1'b0;
    tmo_d     = (state_q == ST_IDLE || fall) ? '0 : tmo_q + TW'(1);
    if (state_q != ST_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES)) begin
      timeout = 1'b1;
      state_d = ST_IDLE;
      tmo_d   = '0;
    end else if (fall) begin
      unique case (state_q)
        ST_IDLE: if (!data_sync_q) begin
          state_d = ST_DATA;
          cnt_d   = 3'd0;
        end
        ST_DATA: begin
          shift_d = {data_sync_q, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = data_sync_q;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          if (data_sync_q && odd_parity_ok(shift_q, parity_q)) byte_done = 1'b1;
          else frame_bad = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign err_now = frame_bad | timeout;

  // Prefix bytes only set flags; the next ordinary code carries them out and clears them.
  always_comb begin
    ext_d   = ext_q;
    rel_d   = rel_q;
    push    = 1'b0;
    push_ev = '{code: shift_q, is_release: rel_q, is_extended: ext_q};
    if (err_now) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (byte_done) begin
      if (shift_q == PS2_EXT_CODE) ext_d = 1'b1;
      else if (shift_q == PS2_BREAK_CODE) rel_d = 1'b1;
      else begin
        push  = 1'b1;
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
  end

  assign pop = ev_valid & ev_ready;

`ifdef PS2_EVENT_FIFO_EN
  logic fifo_full;

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK         (CLK),
    .Resetn      (Resetn),
    .push_i      (push),
    .push_data_i (push_ev),
    .full_o      (fifo_full),
    .pop_valid_o (ev_valid),
    .pop_ready_i (ev_ready),
    .pop_data_o  (out_ev)
  );

  assign drop = push & fifo_full & ~pop;
`else
  logic       hold_valid_q, hold_valid_d;
  key_event_t hold_q, hold_d;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (pop) hold_valid_d = 1'b0;
    if (push && (!hold_valid_q || pop)) begin
      hold_valid_d = 1'b1;
      hold_d       = push_ev;
    end
  end

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
    end
  end

  assign ev_valid = hold_valid_q;
  assign out_ev   = hold_q;
  assign drop     = push & hold_valid_q & ~pop;
`endif

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      frame_err_q <= err_now;
      overflow_q  <= drop;
    end
  end

  assign ev_code     = out_ev.code;
  assign ev_release  = out_ev.is_release;
  assign ev_extended = out_ev.is_extended;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
